// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its instruction-memory load port.
package fetch_pkg;

    typedef enum logic [2:0] {
        HALT,
        LOAD,
        RUN,
        STALL,
        BUBBLE
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Pipeline-control, loader and instruction-memory debug-port signals of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            halt_req;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            ld_req;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_ack;
    logic            ld_err;
    logic [XLEN-1:0] pc;
    logic            fetch_valid;
    logic            dbg_wr_en;
    logic [XLEN-1:0] dbg_addr;
    logic [XLEN-1:0] dbg_instr;
    logic            running;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output start, halt_req, stall, redirect_valid, redirect_pc,
        output ld_req, ld_addr, ld_data,
        input  ld_ack, ld_err, pc, fetch_valid, dbg_wr_en, dbg_addr, dbg_instr,
        input  running, fetch_count
    );

    modport slave (
        input  start, halt_req, stall, redirect_valid, redirect_pc,
        input  ld_req, ld_addr, ld_data,
        output ld_ack, ld_err, pc, fetch_valid, dbg_wr_en, dbg_addr, dbg_instr,
        output running, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer_imem_load_port.sv
// Loader side of the instruction-memory debug port: bounds/alignment check, ack/err pulse,
// and a registered one-cycle write strobe for each accepted word.
module imem_load_port
    import fetch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            accept,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ack,
    output logic            ld_err,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr
);

    // One extra bit so the limit itself is representable when memory spans the whole space.
    localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(IMEM_WORDS * INSTR_BYTES);

    logic            addr_ok;
    logic            ld_ack_d, ld_ack_q;
    logic            ld_err_d, ld_err_q;
    logic            dbg_wr_en_d, dbg_wr_en_q;
    logic [XLEN-1:0] dbg_addr_d, dbg_addr_q;
    logic [XLEN-1:0] dbg_instr_d, dbg_instr_q;

    always_comb begin
        addr_ok     = (ld_addr[1:0] == 2'b00) && ({1'b0, ld_addr} < ADDR_LIMIT);
        ld_ack_d    = accept;
        ld_err_d    = accept && !addr_ok;
        dbg_wr_en_d = accept && addr_ok;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;
        if (accept && addr_ok) begin
            dbg_addr_d  = ld_addr;
            dbg_instr_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ack_q    <= 1'b0;
            ld_err_q    <= 1'b0;
            dbg_wr_en_q <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
        end else begin
            ld_ack_q    <= ld_ack_d;
            ld_err_q    <= ld_err_d;
            dbg_wr_en_q <= dbg_wr_en_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
        end
    end

    assign ld_ack    = ld_ack_q;
    assign ld_err    = ld_err_q;
    assign dbg_wr_en = dbg_wr_en_q;
    assign dbg_addr  = dbg_addr_q;
    assign dbg_instr = dbg_instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner and fetch-stage sequencer; arbitrates the instruction-memory debug
// port between the test loader (HALT/LOAD) and normal fetch (RUN/STALL/BUBBLE).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IMEM_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.slave    bus
);

    fetch_state_t    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] fetch_count_d, fetch_count_q;
    logic            fetch_valid_d, fetch_valid_q;
    logic            running_d, running_q;
    logic            ld_accept;
    logic            ld_ack;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        ld_accept     = 1'b0;

        // A cycle with fetch_valid high is an issued fetch, whatever happens next.
        if (fetch_valid_q && (fetch_count_q != '1))
            fetch_count_d = fetch_count_q + 1'b1;

        case (state_q)
            HALT: begin
                if (bus.ld_req) begin
                    state_d   = LOAD;
                    ld_accept = 1'b1;
                end else if (bus.start) begin
                    state_d       = RUN;
                    pc_d          = RESET_PC;
                    fetch_count_d = '0;
                end
            end
            LOAD: begin
                // The ack cycle ignores ld_req, capping the loader at one word per two cycles.
                if (!ld_ack) begin
                    if (bus.ld_req) ld_accept = 1'b1;
                    else            state_d   = HALT;
                end
            end
            RUN, STALL, BUBBLE: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (bus.redirect_valid) begin
                    pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
                    state_d = bus.stall ? STALL : BUBBLE;
                end else if (bus.stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    if (state_q == RUN) pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            default: state_d = HALT;
        endcase

        fetch_valid_d = (state_d == RUN);
        running_d     = (state_d == RUN) || (state_d == STALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HALT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            fetch_valid_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            fetch_valid_q <= fetch_valid_d;
            running_q     <= running_d;
        end
    end

    imem_load_port #(
        .XLEN       (XLEN),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_load_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (ld_accept),
        .ld_addr   (bus.ld_addr),
        .ld_data   (bus.ld_data),
        .ld_ack    (ld_ack),
        .ld_err    (bus.ld_err),
        .dbg_wr_en (bus.dbg_wr_en),
        .dbg_addr  (bus.dbg_addr),
        .dbg_instr (bus.dbg_instr)
    );

    assign bus.ld_ack      = ld_ack;
    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.running     = running_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
